// File: rtl/wb_b3_line_master.sv
// rtl/wb_b3_line_master.sv - Wishbone B3 registered-feedback line burst master
//
// Turns one line request (BEATS x 32-bit words) into a single Wishbone B3
// incrementing burst with cti/bte, and reports completion and bus errors.
//
// Optional build macro: WB_LINE_MASTER_CRITICAL_WORD_EN
//   defined   : burst starts at the requested word and wraps (bte 01/10/11)
//   undefined : burst starts at the line base, linear (bte 00)
//
// Ports:
//   wb_clk_i, wb_rst_i (async, active-low)
//   req_valid_i/req_ready_o/req_we_i/req_adr_i/req_wdata_i : line request
//   resp_valid_o/resp_err_o/resp_rdata_o                   : line completion
//   wb_adr_o/wb_cti_o/wb_bte_o/wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/wb_dat_o
//   wb_dat_i/wb_ack_i/wb_err_i/wb_rty_i                    : slave response
module wb_b3_line_master #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int BEATS = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [AW-1:0]       req_adr_i,
   input  logic [DW*BEATS-1:0] req_wdata_i,
   output logic                resp_valid_o,
   output logic                resp_err_o,
   output logic [DW*BEATS-1:0] resp_rdata_o,
   output logic [AW-1:0]       wb_adr_o,
   output logic [2:0]          wb_cti_o,
   output logic [1:0]          wb_bte_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [3:0]          wb_sel_o,
   output logic [DW-1:0]       wb_dat_o,
   input  logic [DW-1:0]       wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_err_i,
   input  logic                wb_rty_i
);

   localparam int LB = $clog2(BEATS);
   localparam logic [AW-1:0] OFF_MASK = AW'(BEATS * 4 - 1);

`ifdef WB_LINE_MASTER_CRITICAL_WORD_EN
   localparam logic [1:0] BTE = (BEATS == 4) ? 2'b01 : (BEATS == 8) ? 2'b10 : 2'b11;
`else
   localparam logic [1:0] BTE = 2'b00;
`endif

   typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

   state_t              state_q;
   logic                we_q;
   logic [AW-1:0]       base_q;
   logic [LB-1:0]       start_q;
   logic [LB-1:0]       cnt_q;
   logic [DW*BEATS-1:0] wline_q;
   logic [DW*BEATS-1:0] rdata_q;
   logic                ready_q;
   logic                rvalid_q;
   logic                rerr_q;
   logic [AW-1:0]       adr_q;
   logic [2:0]          cti_q;
   logic [1:0]          bte_q;
   logic                cyc_q;
   logic                stb_q;
   logic                wbwe_q;
   logic [3:0]          sel_q;
   logic [DW-1:0]       dat_q;

   logic [AW-1:0]       base_d;
   logic [LB-1:0]       start_d;
   logic [LB-1:0]       idx_d;
   logic [LB-1:0]       idx_nxt_d;
   logic                last_d;
   logic                term_err_d;
   logic [2:0]          cti_nxt_d;

   always_comb begin
      base_d     = req_adr_i & ~OFF_MASK;
`ifdef WB_LINE_MASTER_CRITICAL_WORD_EN
      start_d    = req_adr_i[LB+1:2];
`else
      start_d    = '0;
`endif
      // LB-bit addition wraps modulo BEATS, which gives the wrap-burst order
      idx_d      = start_q + cnt_q;
      idx_nxt_d  = idx_d + 1'b1;
      last_d     = (cnt_q == LB'(BEATS - 1));
      term_err_d = wb_err_i | wb_rty_i;
      // cti for the beat after this one: end-of-burst once cnt reaches BEATS-1
      cti_nxt_d  = (cnt_q == LB'(BEATS - 2)) ? 3'b111 : 3'b010;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         base_q   <= '0;
         start_q  <= '0;
         cnt_q    <= '0;
         wline_q  <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         adr_q    <= '0;
         cti_q    <= 3'b000;
         bte_q    <= 2'b00;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         wbwe_q   <= 1'b0;
         sel_q    <= 4'h0;
         dat_q    <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (req_valid_i && ready_q) begin
                  ready_q <= 1'b0;
                  we_q    <= req_we_i;
                  base_q  <= base_d;
                  start_q <= start_d;
                  cnt_q   <= '0;
                  wline_q <= req_wdata_i;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  wbwe_q  <= req_we_i;
                  sel_q   <= 4'hF;
                  bte_q   <= BTE;
                  cti_q   <= 3'b010;
                  adr_q   <= base_d | (AW'(start_d) << 2);
                  dat_q   <= req_wdata_i[DW*start_d +: DW];
                  state_q <= BURST;
               end
            end
            BURST: begin
               // err/rty takes precedence over a simultaneous ack: no data stored
               if (wb_ack_i && !term_err_d && !we_q) begin
                  rdata_q[DW*idx_d +: DW] <= wb_dat_i;
               end
               if (term_err_d || (wb_ack_i && last_d)) begin
                  cyc_q    <= 1'b0;
                  stb_q    <= 1'b0;
                  wbwe_q   <= 1'b0;
                  sel_q    <= 4'h0;
                  cti_q    <= 3'b000;
                  bte_q    <= 2'b00;
                  adr_q    <= '0;
                  dat_q    <= '0;
                  rvalid_q <= 1'b1;
                  rerr_q   <= term_err_d;
                  state_q  <= RESP;
               end else if (wb_ack_i) begin
                  // advance on the acking edge so the address tracks the slave counter
                  cnt_q <= cnt_q + 1'b1;
                  adr_q <= base_q | (AW'(idx_nxt_d) << 2);
                  dat_q <= wline_q[DW*idx_nxt_d +: DW];
                  cti_q <= cti_nxt_d;
               end
            end
            RESP: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = ready_q;
   assign resp_valid_o = rvalid_q;
   assign resp_err_o   = rerr_q;
   assign resp_rdata_o = rdata_q;
   assign wb_adr_o     = adr_q;
   assign wb_cti_o     = cti_q;
   assign wb_bte_o     = bte_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = stb_q;
   assign wb_we_o      = wbwe_q;
   assign wb_sel_o     = sel_q;
   assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_b3_line_master.sv
// tb/tb_wb_b3_line_master.sv - scoreboard bench for wb_b3_line_master against a Wishbone RAM model
`timescale 1ns/1ps
module tb_wb_b3_line_master;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int BEATS     = 4;
   localparam int LW        = DW * BEATS;
   localparam int MEM_BYTES = 128 * 1024;
   localparam int MEM_WORDS = MEM_BYTES / 4;

`ifdef WB_LINE_MASTER_CRITICAL_WORD_EN
   localparam logic [1:0] EXP_BTE = (BEATS == 4) ? 2'b01 : (BEATS == 8) ? 2'b10 : 2'b11;
`else
   localparam logic [1:0] EXP_BTE = 2'b00;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready_o, req_we;
   logic [AW-1:0] req_adr;
   logic [LW-1:0] req_wdata;
   logic          resp_valid_o, resp_err_o;
   logic [LW-1:0] resp_rdata_o;
   logic [AW-1:0] wb_adr_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]    wb_sel_o;
   logic [DW-1:0] wb_dat_o, wb_dat_i;
   logic          s_ack, s_err, s_rty;

   always #5 clk = ~clk;

   wb_b3_line_master #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
      .req_adr_i(req_adr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
      .wb_adr_o(wb_adr_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'hC0DE0000;
   endfunction

   // ---------------- RAM slave model: 128 KB, err above, rty from 0x30000 ----------------
   logic [31:0] mem [0:MEM_WORDS-1];
   bit          mem_ready;
   int          s_beat, s_stalls;
   int          cfg_wait_beat = -1;
   int          cfg_stalls    = 0;

   assign wb_dat_i = mem[wb_adr_o[16:2]];

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (rst_n && wb_cyc_o && wb_we_o && s_ack) begin
         mem[wb_adr_o[16:2]] <= wb_dat_o;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0; s_beat <= 0; s_stalls <= 0;
      end else begin
         s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0;
         if (!wb_cyc_o) begin
            s_beat <= 0; s_stalls <= 0;
         end else begin
            s_beat <= s_beat + (s_ack ? 1 : 0);
            if (wb_stb_o && !(s_err || s_rty) && !(s_ack && wb_cti_o == 3'b111)) begin
               if (wb_adr_o >= 32'h30000) s_rty <= 1'b1;
               else if (wb_adr_o >= MEM_BYTES) s_err <= 1'b1;
               else if ((s_beat + (s_ack ? 1 : 0)) == cfg_wait_beat && s_stalls < cfg_stalls)
                  s_stalls <= s_stalls + 1;
               else s_ack <= 1'b1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] adr;
      logic [2:0]  cti;
      logic        we;
      logic [31:0] dat;
   } beat_t;

   typedef struct {
      logic          err;
      logic [LW-1:0] rdata;
      int            acc;
      int            lat;
   } resp_t;

   beat_t beat_q[$];
   resp_t resp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    cycle    = 0;
   int    beats_seen = 0;
   int    resp_count = 0;
   int    resp_target = 0;

   logic [31:0]   ref_mem [0:MEM_WORDS-1];
   logic [LW-1:0] model_rdata;

   task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (rst_n && wb_cyc_o && wb_stb_o && (s_ack || s_err || s_rty)) begin
         beat_t b;
         check("beat_expected", beat_q.size() > 0, 1'b1);
         if (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            check("beat_adr", wb_adr_o, b.adr);
            check("beat_cti", wb_cti_o, b.cti);
            check("beat_bte", wb_bte_o, EXP_BTE);
            check("beat_we", wb_we_o, b.we);
            check("beat_sel", wb_sel_o, 4'hF);
            if (b.we) check("beat_wdat", wb_dat_o, b.dat);
         end
         beats_seen++;
      end
   end

   always @(negedge clk) begin
      if (rst_n && resp_valid_o) begin
         resp_t r;
         check("resp_expected", resp_q.size() > 0, 1'b1);
         if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            check("resp_err", resp_err_o, r.err);
            check("resp_rdata", resp_rdata_o, r.rdata);
            check("resp_latency", cycle - r.acc, r.lat);
            check("resp_cyc_low", {wb_cyc_o, wb_stb_o}, 2'b00);
         end
         resp_count++;
      end
   end

   // ---------------- driver with line-level reference model ----------------
   task automatic start_req(input bit we, input logic [31:0] adr, input logic [LW-1:0] wd,
                            input int wbeat, input int nstall, input bit track);
      logic [31:0] base;
      int          start, tries, widx;
      bit          oob;
      beat_t       b;
      resp_t       r;
      base = adr & ~32'(BEATS * 4 - 1);
`ifdef WB_LINE_MASTER_CRITICAL_WORD_EN
      start = int'((adr >> 2) % BEATS);
`else
      start = 0;
`endif
      oob = (base >= MEM_BYTES);
      tries = 0;
      @(negedge clk);
      while (!req_ready_o && tries < 100) begin
         @(negedge clk);
         tries++;
      end
      check("req_ready", req_ready_o, 1'b1);
      cfg_wait_beat = wbeat;
      cfg_stalls    = nstall;
      for (int k = 0; k < BEATS; k++) begin
         widx  = (start + k) % BEATS;
         b.adr = base + 32'(widx * 4);
         b.cti = (k == BEATS - 1) ? 3'b111 : 3'b010;
         b.we  = we;
         b.dat = wd[32*widx +: 32];
         beat_q.push_back(b);
         if (oob) break;
      end
      if (!oob) begin
         for (int i = 0; i < BEATS; i++) begin
            if (we) ref_mem[int'(base >> 2) + i] = wd[32*i +: 32];
            else    model_rdata[32*i +: 32] = ref_mem[int'(base >> 2) + i];
         end
      end
      r.err   = oob;
      r.rdata = model_rdata;
      r.acc   = cycle;
      r.lat   = oob ? 3 : BEATS + 2 + ((wbeat >= 0) ? nstall : 0);
      if (track) begin
         resp_q.push_back(r);
         resp_target++;
      end
      req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int n = 0;
      while (resp_count < resp_target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("resp_arrived", resp_count >= resp_target, 1'b1);
   endtask

   task automatic do_req(input bit we, input logic [31:0] adr, input logic [LW-1:0] wd,
                         input int wbeat, input int nstall);
      start_req(we, adr, wd, wbeat, nstall, 1'b1);
      wait_resp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] wd;
      int            b0, n, wbeat, nstall;
      logic [31:0]   adr;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
      model_rdata = '0;
      req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, req_ready_o, resp_valid_o, resp_err_o}, 6'b0);
      check("rst_bus", {wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o, wb_dat_o}, '0);
      check("rst_rdata", resp_rdata_o, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", req_ready_o, 1'b1);

      // critical-word example line, then a known write/readback
      do_req(1'b0, 32'h0000_0108, '0, -1, 0);
      for (int i = 0; i < BEATS; i++) wd[32*i +: 32] = 32'(i) * 32'h1111_1111;
      do_req(1'b1, 32'h0000_0200, wd, -1, 0);
      do_req(1'b0, 32'h0000_0200, '0, -1, 0);
      check("readback_line", resp_rdata_o, wd);
      // out-of-range line: error on the first beat
      do_req(1'b0, 32'h0002_0000, '0, -1, 0);
      // three wait states on beat 2
      do_req(1'b0, 32'h0000_0300, '0, 2, 3);

      // reset in the middle of a read burst
      b0 = beats_seen;
      start_req(1'b0, 32'h0000_0404, '0, -1, 0, 1'b0);
      n = 0;
      while (beats_seen < b0 + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_beats", beats_seen >= b0 + 2, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_burst", {wb_cyc_o, wb_stb_o, resp_valid_o, req_ready_o}, 4'b0);
      beat_q.delete();
      model_rdata = '0;
      repeat (3) begin
         @(negedge clk);
         check("rst_hold", {wb_cyc_o, wb_stb_o, resp_valid_o, req_ready_o}, 4'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_mid_reset", req_ready_o, 1'b1);
      do_req(1'b0, 32'h0000_0404, '0, -1, 0);

      // randomized traffic confined to a small window so reads hit earlier writes
      for (int t = 0; t < 30; t++) begin
         n = $urandom_range(0, 9);
         if (n == 0)      adr = 32'h0002_0000 + 32'($urandom_range(0, 4095) * 4);
         else if (n == 1) adr = 32'h0003_0000 + 32'($urandom_range(0, 4095) * 4);
         else             adr = 32'($urandom_range(0, 255) * 4);
         for (int i = 0; i < BEATS; i++) wd[32*i +: 32] = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            wbeat  = $urandom_range(0, BEATS - 1);
            nstall = $urandom_range(1, 4);
         end else begin
            wbeat  = -1;
            nstall = 0;
         end
         do_req(1'($urandom_range(0, 1)), adr, wd, wbeat, nstall);
      end

      repeat (4) @(negedge clk);
      check("beat_q_drained", beat_q.size(), 0);
      check("resp_q_drained", resp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
